// File: rtl/bus_timer.sv
// Memory-mapped timer responder: prescaled 32-bit up-counter, compare register,
// sticky match flag and level interrupt, with a one-cycle registered bus ack.
module bus_timer #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
    parameter logic [31:0] RESET_PRESCALE = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        irq_o
);

    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_COUNT    = 6'h01;
    localparam logic [5:0] OFF_COMPARE  = 6'h02;
    localparam logic [5:0] OFF_STATUS   = 6'h03;
    localparam logic [5:0] OFF_PRESCALE = 6'h04;

    state_t      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] rdata_q, rdata_d;

    logic        inWindow;
    logic        sel;
    logic        wrSel;
    logic [5:0]  offset;
    logic        tick;
    logic        countWr;
    logic [31:0] readData;
    logic        unused_addr;

    assign inWindow    = (addr_i[31:8] == BASE_ADDRESS[31:8]);
    assign sel         = (rd_en_i | wr_en_i) & inWindow;
    assign wrSel       = sel & wr_en_i;
    assign offset      = addr_i[7:2];
    assign countWr     = wrSel && (offset == OFF_COUNT);
    assign unused_addr = ^addr_i[1:0];

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (!ctrl_q[0]) begin
            presc_d = '0;
        end else if (presc_q == prescale_q) begin
            presc_d = '0;
            tick    = 1'b1;
        end else begin
            presc_d = presc_q + 32'd1;
        end
    end

    // A bus write to COUNT drops that cycle's tick entirely; a match set beats a STATUS clear.
    always_comb begin
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;
        prescale_d = prescale_q;

        if (wrSel) begin
            case (offset)
                OFF_CTRL:     ctrl_d     = data_i[2:0];
                OFF_COUNT:    count_d    = data_i;
                OFF_COMPARE:  compare_d  = data_i;
                OFF_STATUS:   if (data_i[0]) match_d = 1'b0;
                OFF_PRESCALE: prescale_d = data_i;
                default:      ;
            endcase
        end

        if (tick && !countWr) begin
            if (count_q == compare_q) begin
                match_d = 1'b1;
                count_d = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_comb begin
        readData = '0;
        case (offset)
            OFF_CTRL:     readData = {29'd0, ctrl_q};
            OFF_COUNT:    readData = count_q;
            OFF_COMPARE:  readData = compare_q;
            OFF_STATUS:   readData = {31'd0, match_q};
            OFF_PRESCALE: readData = prescale_q;
            default:      readData = '0;
        endcase
        rdata_d = sel ? readData : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            count_q    <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            prescale_q <= RESET_PRESCALE;
            presc_q    <= '0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            prescale_q <= prescale_d;
            presc_q    <= presc_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = sel ? ACK : IDLE;
            ACK:     state_d = sel ? ACK : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_o  = (state_q == ACK);
        data_o = ack_o ? rdata_q : '0;
        irq_o  = match_q & ctrl_q[2];
    end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped timer peripheral that answers the core's memory bus as a responder. It sits beside the main memory on the same rd_en/wr_en/addr/data/ack bus and decodes its own address window. It provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt. Each accepted access completes with a one-cycle ack.

## Interface
- BASE_ADDRESS, 32'h8000_0000: window base; the block responds when addr_i[31:8] == BASE_ADDRESS[31:8].
- RESET_PRESCALE, 32'd0: reset value of PRESCALE.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rd_en_i  input  1  read request, sampled each cycle.
- wr_en_i  input  1  write request, sampled each cycle.
- addr_i  input  32  byte address; offset = addr_i[7:2] (word index); addr_i[1:0] ignored.
- data_i  input  32  write data, sampled with wr_en_i.
- data_o  output  32  read data; valid only while ack_o=1, otherwise 0.
- ack_o  output  1  one-cycle completion pulse for an accepted access.
- irq_o  output  1  level interrupt = STATUS.match & CTRL.irq_en.

## Operation
- Register map (offsets):
  - 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en, other bits read 0.
  - 0x04 COUNT: read/write.
  - 0x08 COMPARE: read/write.
  - 0x0C STATUS: bit0 match; write 1 to clear; write 0 has no effect.
  - 0x10 PRESCALE: read/write.
- Unmapped offsets inside the window read 0, ignore writes, and still ack.
- Access is selected when (rd_en_i | wr_en_i) and the address is in the window. An unselected cycle produces no ack and no state change.
- Access priority:
  - If rd_en_i and wr_en_i are both high, the write executes.
  - In that case data_o returns the value of the register *before* the write.
- Ack FSM has two states.
  - IDLE: a selected access moves the FSM to ACK.
  - ACK: ack_o=1 and data_o=read data. A new selected access keeps the FSM in ACK; otherwise it returns to IDLE.
- Prescaler (internal, 32-bit):
  - While enable=1, it increments every cycle.
  - When it equals PRESCALE, it returns to 0 and produces a tick.
  - A tick therefore occurs every PRESCALE+1 cycles.
  - While enable=0, the prescaler is held at 0.
- On a tick:
  - If COUNT == COMPARE: set match. Then COUNT <= 0 if auto_reload, else COUNT <= COUNT+1.
  - Otherwise: COUNT <= COUNT+1.
  - COUNT wraps modulo 2^32 (FFFF_FFFF -> 0).
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the bus write wins, and the tick's compare/increment is dropped.
  - A STATUS clear in the same cycle as a match set: the set wins, so match stays 1.
  - A write to PRESCALE takes effect from the next cycle. If the new value is below the current prescaler value, the prescaler continues counting up until it wraps at 2^32.
- Reset values: CTRL=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0, PRESCALE=RESET_PRESCALE, prescaler=0, FSM=IDLE, ack_o=0, data_o=0, irq_o=0.

## Timing
- Access latency: request sampled at edge N; ack_o and data_o are high at edge N+1 for exactly one cycle per accepted request.
- Back-to-back accesses are accepted every cycle: ack_o stays high, and data_o changes each cycle.
- Write effects are visible from the cycle after the sampling edge. A read issued the cycle after a write returns the new value.
- Read data is registered at the sampling edge and reflects register contents before that edge's updates, including ticks.
- Match set and irq_o assertion occur one cycle after the tick edge on which COUNT == COMPARE was evaluated. irq_o comes from registers, with no combinational path from the bus.
- Reset mid-access: asserting rst_n=0 forces ack_o=0, data_o=0 and irq_o=0 immediately (asynchronous). The pending access is dropped and not acked after reset release.

## Test plan
- Reset and readback: after reset, read 0x00, 0x04, 0x08, 0x0C and 0x10. Required: 0, 0, FFFF_FFFF, 0, RESET_PRESCALE, each with ack_o high exactly one cycle after its request.
- Decode: a read at BASE+0x100 produces no ack. A read at BASE+0x3C acks with 0. Write 0x1234 to COMPARE at BASE+0x0B (byte offset ignored), then read 0x08 and expect 0x1234.
- Prescaled count: PRESCALE=3, CTRL=1. After 40 cycles COUNT=10 (±1 for write alignment). Then write CTRL=0; COUNT freezes and the prescaler resets.
- Compare and irq, auto-reload: PRESCALE=0, COMPARE=5, CTRL=7. Required: COUNT runs 0..5 then returns to 0. match=1, and irq_o rises one cycle after the tick at COUNT=5. Writing 1 to STATUS clears irq_o. Writing 0 to STATUS does not clear it.
- Wrap and conflicts:
  - COUNT=FFFF_FFFF, COMPARE=0, auto_reload=0: the next tick gives COUNT=0, and the following tick sets match.
  - A COUNT write on a tick cycle leaves the written value.
  - A STATUS clear on a match cycle leaves match=1.
- Back-to-back and reset: four consecutive-cycle reads give four consecutive ack cycles with correct data. Simultaneous rd_en_i/wr_en_i to COMPARE returns the old value and stores the new one. Pulling rst_n low during an ack cycle drops ack_o immediately.
